// File: rtl/pet_stat_bank.sv
// pet_stat_bank: saturating pet-stat register bank with tick-driven decay,
// button/sensor effects and a registered pet state for the display driver.
module pet_stat_bank #(
   parameter int NUM_STATS    = 4,
   parameter int STAT_W       = 6,
   parameter int STAT_MAX     = 63,
   parameter int STAT_INIT    = 40,
   parameter int INC_STEP     = 4,
   parameter int TICK_DIV     = 50_000_000,
   parameter int TEST_SPEEDUP = 10,
   parameter int DECAY_PERIOD = 10,
   parameter int LOW_TH       = 10,
   parameter int HIGH_TH      = 48,
   parameter int SEL_W        = $clog2(NUM_STATS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          test,
   input  logic                          btn_next,
   input  logic                          btn_back,
   input  logic                          btn_comer_inc,
   input  logic                          btn_curar_dec,
   input  logic                          sns_prox,
   input  logic                          sns_temp,
   input  logic                          sns_luz,
   output logic [SEL_W-1:0]              stat_sel,
   output logic [STAT_W-1:0]             stat_value,
   output logic [NUM_STATS*STAT_W-1:0]   stats_flat,
   output logic [3:0]                    state,
   output logic                          decay_evt
);
   localparam int PW = $clog2(TICK_DIV + 1);
   localparam int DW = $clog2(DECAY_PERIOD + 1);
   localparam int AW = STAT_W + 2;
   localparam int LIM_N = TICK_DIV;
   localparam int LIM_T = TICK_DIV / TEST_SPEEDUP;

   typedef enum logic [3:0] {
      ST_HAPPY  = 4'd0,
      ST_NORMAL = 4'd1,
      ST_SAD    = 4'd2,
      ST_SLEEP  = 4'd3,
      ST_DEAD   = 4'd4
   } state_t;

   logic [6:0]          in_raw, s1_q, s1_d, s2_q, s2_d;
   logic [4:0]          s3_q, s3_d, edg;
   logic                nxt_e, bck_e, inc_e, dec_e, prx_e, temp_s, luz_s, val_e;
   logic                test_q, test_d, tick, decay, decay_evt_q, decay_evt_d;
   logic [PW-1:0]       pcnt_q, pcnt_d;
   logic [DW-1:0]       dcnt_q, dcnt_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [STAT_W-1:0]   stat_q [NUM_STATS];
   logic [STAT_W-1:0]   stat_d [NUM_STATS];
   logic                any_zero, any_low, all_high, frozen;
   state_t              state_q, state_d;

   assign in_raw = {sns_luz, sns_temp, sns_prox, btn_curar_dec, btn_comer_inc, btn_back, btn_next};

   always_comb begin
      s1_d        = in_raw;
      s2_d        = s1_q;
      s3_d        = s2_q[4:0];
      edg         = s2_q[4:0] & ~s3_q;
      nxt_e       = edg[0];
      bck_e       = edg[1];
      inc_e       = edg[2];
      dec_e       = edg[3];
      prx_e       = edg[4];
      temp_s      = s2_q[5];
      luz_s       = s2_q[6];
      val_e       = inc_e ^ dec_e;
      test_d      = test;
      // a mode switch restarts the prescaler instead of ticking
      tick        = (test == test_q) && (pcnt_q == (test_q ? PW'(LIM_T - 1) : PW'(LIM_N - 1)));
      pcnt_d      = (test != test_q || tick) ? '0 : pcnt_q + 1'b1;
      decay       = tick && (dcnt_q == DW'(DECAY_PERIOD - 1));
      dcnt_d      = !tick ? dcnt_q : decay ? '0 : dcnt_q + 1'b1;
      decay_evt_d = decay;
      sel_d       = (nxt_e && !bck_e) ? ((sel_q == SEL_W'(NUM_STATS - 1)) ? '0 : sel_q + 1'b1) :
                    (bck_e && !nxt_e) ? ((sel_q == '0) ? SEL_W'(NUM_STATS - 1) : sel_q - 1'b1) :
                    sel_q;
      any_zero    = 1'b0;
      any_low     = 1'b0;
      all_high    = 1'b1;
      for (int i = 0; i < NUM_STATS; i++) begin
         any_zero = any_zero | (stat_q[i] == '0);
         any_low  = any_low  | (stat_q[i] < STAT_W'(LOW_TH));
         all_high = all_high & (stat_q[i] >= STAT_W'(HIGH_TH));
      end
      frozen      = (state_q == ST_DEAD) || any_zero;
      state_d     = frozen   ? ST_DEAD  :
                    !luz_s   ? ST_SLEEP :
                    any_low  ? ST_SAD   :
                    all_high ? ST_HAPPY : ST_NORMAL;
   end

   // the selected channel takes the button result in place of decay; sums are
   // two's complement so the MSB flags an underflow before clamping
   for (genvar g = 0; g < NUM_STATS; g++) begin : g_ch
      logic           hit;
      logic [AW-1:0]  dec_amt, dlt, sum;
      assign hit     = val_e && (sel_q == SEL_W'(g));
      assign dec_amt = (g == 0 && !luz_s) ? AW'(1) : (g == 3 && temp_s) ? AW'(-2) : AW'(-1);
      assign dlt     = hit ? (inc_e ? AW'(INC_STEP) : -AW'(INC_STEP)) : decay ? dec_amt : '0;
      assign sum     = AW'(stat_q[g]) + dlt + ((g == 1 && prx_e) ? AW'(1) : '0);
      assign stat_d[g] = frozen ? stat_q[g] :
                         sum[AW-1] ? '0 :
                         (sum > AW'(STAT_MAX)) ? STAT_W'(STAT_MAX) : sum[STAT_W-1:0];
      assign stats_flat[g*STAT_W +: STAT_W] = stat_q[g];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q        <= '0;
         s2_q        <= '0;
         s3_q        <= '0;
         test_q      <= 1'b0;
         pcnt_q      <= '0;
         dcnt_q      <= '0;
         decay_evt_q <= 1'b0;
         sel_q       <= '0;
         state_q     <= ST_NORMAL;
         for (int i = 0; i < NUM_STATS; i++) stat_q[i] <= STAT_W'(STAT_INIT);
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         s3_q        <= s3_d;
         test_q      <= test_d;
         pcnt_q      <= pcnt_d;
         dcnt_q      <= dcnt_d;
         decay_evt_q <= decay_evt_d;
         sel_q       <= sel_d;
         state_q     <= state_d;
         stat_q      <= stat_d;
      end
   end

   assign stat_sel   = sel_q;
   assign stat_value = stat_q[sel_q];
   assign state      = state_q;
   assign decay_evt  = decay_evt_q;
endmodule
